collision_score: RTL and testbench

Collision and scoring stage directly downstream of the bird flight-physics block. It compares the bird's bounding box against two scrolling pipe obstacles plus the floor and ceiling, and raises `Stop` back to the physics block on any hit. It holds `Stop` until the game FSM acknowledges, and keeps a 2-digit BCD score and a high score for the VGA overlay.

---
 rtl/collision_score.sv | 169 ++++++++++++++++
 tb/tb_collision_score.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_score.sv
// collision_score
//   Collision and scoring stage that sits after the bird flight-physics block.
//   Stage 1 registers the geometry tests every cycle. Stage 2 is a one-hot
//   game FSM that raises Stop on a hit and holds it until Ack. It also keeps
//   a saturating 2-digit BCD score and a high score.
//
// Ports
//   Clk, reset            clock; asynchronous active-high reset
//   q_Flight              physics block is in flight; starts a game from idle
//   Ack                   game FSM acknowledge; releases Stop
//   Bird_X_L/X_R/Y_T/Y_B  bird bounding box (pixels)
//   Pk_X_L/X_R            pipe k column edges, k = 0,1
//   Pk_Gap_T/Gap_B        pipe k gap top/bottom
//   Stop                  collision detected, held until Ack
//   Score, HighScore      BCD {tens, ones}
//   HitCause              00 none, 01 pipe, 10 floor, 11 ceiling
//   q_Idle/q_Play/q_Hit   one-hot state outputs
module collision_score #(
    parameter logic [9:0] FLOOR_Y = 10'd480,
    parameter logic [9:0] CEIL_Y  = 10'd0
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       q_Flight,
    input  logic       Ack,
    input  logic [9:0] Bird_X_L,
    input  logic [9:0] Bird_X_R,
    input  logic [9:0] Bird_Y_T,
    input  logic [9:0] Bird_Y_B,
    input  logic [9:0] P0_X_L,
    input  logic [9:0] P0_X_R,
    input  logic [9:0] P0_Gap_T,
    input  logic [9:0] P0_Gap_B,
    input  logic [9:0] P1_X_L,
    input  logic [9:0] P1_X_R,
    input  logic [9:0] P1_Gap_T,
    input  logic [9:0] P1_Gap_B,
    output logic       Stop,
    output logic [7:0] Score,
    output logic [7:0] HighScore,
    output logic [1:0] HitCause,
    output logic       q_Idle,
    output logic       q_Play,
    output logic       q_Hit
);

    typedef enum logic [2:0] {
        QIdle = 3'b001,
        QPlay = 3'b010,
        QHit  = 3'b100
    } state_t;

    state_t state, state_nx;

    logic pipe_hit_0_r, pipe_hit_1_r, floor_hit_r, ceil_hit_r;
    logic behind_0_r, behind_1_r;
    logic passed_0, passed_1;
    logic any_hit, pass_0, pass_1;
    logic [1:0] cause_nx;
    logic [7:0] score_p1, score_p2;

    // Adds one to a BCD score, holding at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [7:0] r;
        if (s == 8'h99)
            r = s;
        else if (s[3:0] == 4'd9)
            r = {s[7:4] + 4'd1, 4'd0};
        else
            r = {s[7:4], s[3:0] + 4'd1};
        return r;
    endfunction

    // Stage 1: geometry tests, registered in every state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            pipe_hit_0_r <= 1'b0;
            pipe_hit_1_r <= 1'b0;
            floor_hit_r  <= 1'b0;
            ceil_hit_r   <= 1'b0;
            behind_0_r   <= 1'b0;
            behind_1_r   <= 1'b0;
        end else begin
            pipe_hit_0_r <= (Bird_X_R > P0_X_L) && (Bird_X_L < P0_X_R) &&
                            ((Bird_Y_T < P0_Gap_T) || (Bird_Y_B > P0_Gap_B));
            pipe_hit_1_r <= (Bird_X_R > P1_X_L) && (Bird_X_L < P1_X_R) &&
                            ((Bird_Y_T < P1_Gap_T) || (Bird_Y_B > P1_Gap_B));
            floor_hit_r  <= Bird_Y_B >= FLOOR_Y;
            ceil_hit_r   <= Bird_Y_T <= CEIL_Y;
            behind_0_r   <= P0_X_R < Bird_X_L;
            behind_1_r   <= P1_X_R < Bird_X_L;
        end
    end

    assign any_hit  = pipe_hit_0_r | pipe_hit_1_r | floor_hit_r | ceil_hit_r;
    assign pass_0   = behind_0_r & ~passed_0;
    assign pass_1   = behind_1_r & ~passed_1;
    assign score_p1 = bcd_inc(Score);
    assign score_p2 = bcd_inc(score_p1);

    // Floor outranks ceiling, and ceiling outranks pipe.
    always_comb begin
        cause_nx = 2'b01;
        if (floor_hit_r)
            cause_nx = 2'b10;
        else if (ceil_hit_r)
            cause_nx = 2'b11;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset)
            state <= QIdle;
        else
            state <= state_nx;
    end

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = QIdle;
        case (state)
            QIdle:   state_nx = q_Flight ? QPlay : QIdle;
            QPlay:   state_nx = any_hit ? QHit : QPlay;
            QHit:    state_nx = Ack ? QIdle : QHit;
            default: state_nx = QIdle;
        endcase
    end

    // Score, pass flags, cause and high score.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            Score     <= 8'h00;
            HighScore <= 8'h00;
            HitCause  <= 2'b00;
            passed_0  <= 1'b0;
            passed_1  <= 1'b0;
        end else if (state == QIdle && q_Flight) begin
            Score    <= 8'h00;
            HitCause <= 2'b00;
            passed_0 <= 1'b0;
            passed_1 <= 1'b0;
        end else if (state == QPlay) begin
            if (any_hit) begin
                // A hit beats a pass in the same cycle. BCD digits compare
                // correctly as plain binary.
                HitCause <= cause_nx;
                if (Score > HighScore)
                    HighScore <= Score;
            end else begin
                // Set on the first behind cycle, held while behind, and
                // cleared once the pipe is back in front of the bird.
                passed_0 <= behind_0_r;
                passed_1 <= behind_1_r;
                if (pass_0 && pass_1)
                    Score <= score_p2;
                else if (pass_0 || pass_1)
                    Score <= score_p1;
            end
        end
    end

    assign Stop   = (state == QHit);
    assign q_Idle = (state == QIdle);
    assign q_Play = (state == QPlay);
    assign q_Hit  = (state == QHit);

endmodule

// File: tb/tb_collision_score.sv
// Self-checking bench for collision_score. Expected output snapshots are
// pushed to a scoreboard when stimulus is driven, then popped and compared
// once the DUT has had time to respond.
module tb_collision_score;

    logic       Clk = 1'b0;
    logic       reset;
    logic       q_Flight, Ack;
    logic [9:0] Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
    logic [9:0] P0_X_L, P0_X_R, P0_Gap_T, P0_Gap_B;
    logic [9:0] P1_X_L, P1_X_R, P1_Gap_T, P1_Gap_B;
    logic       Stop;
    logic [7:0] Score, HighScore;
    logic [1:0] HitCause;
    logic       q_Idle, q_Play, q_Hit;

    collision_score dut (
        .Clk(Clk), .reset(reset), .q_Flight(q_Flight), .Ack(Ack),
        .Bird_X_L(Bird_X_L), .Bird_X_R(Bird_X_R),
        .Bird_Y_T(Bird_Y_T), .Bird_Y_B(Bird_Y_B),
        .P0_X_L(P0_X_L), .P0_X_R(P0_X_R), .P0_Gap_T(P0_Gap_T), .P0_Gap_B(P0_Gap_B),
        .P1_X_L(P1_X_L), .P1_X_R(P1_X_R), .P1_Gap_T(P1_Gap_T), .P1_Gap_B(P1_Gap_B),
        .Stop(Stop), .Score(Score), .HighScore(HighScore), .HitCause(HitCause),
        .q_Idle(q_Idle), .q_Play(q_Play), .q_Hit(q_Hit)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      tag;
        logic [2:0] st;     // {q_Hit, q_Play, q_Idle}
        logic       stop;
        logic [7:0] score;
        logic [7:0] hs;
        logic [1:0] cause;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_PLAY = 3'b010;
    localparam logic [2:0] S_HIT  = 3'b100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] st, input logic stop,
                              input logic [7:0] score, input logic [7:0] hs,
                              input logic [1:0] cause);
        exp_t e;
        e.tag = tag; e.st = st; e.stop = stop; e.score = score; e.hs = hs; e.cause = cause;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".state"}, {29'd0, q_Hit, q_Play, q_Idle}, {29'd0, e.st});
            check({e.tag, ".stop"},  {31'd0, Stop}, {31'd0, e.stop});
            check({e.tag, ".score"}, {24'd0, Score}, {24'd0, e.score});
            check({e.tag, ".hs"},    {24'd0, HighScore}, {24'd0, e.hs});
            check({e.tag, ".cause"}, {30'd0, HitCause}, {30'd0, e.cause});
        end
    endtask

    // Sample 1 time unit after the rising edge; inputs change there too.
    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_bird(input int xl, input int xr, input int yt, input int yb);
        Bird_X_L = 10'(xl); Bird_X_R = 10'(xr); Bird_Y_T = 10'(yt); Bird_Y_B = 10'(yb);
    endtask

    task automatic set_p0(input int xl, input int xr, input int gt, input int gb);
        P0_X_L = 10'(xl); P0_X_R = 10'(xr); P0_Gap_T = 10'(gt); P0_Gap_B = 10'(gb);
    endtask

    task automatic set_p1(input int xl, input int xr, input int gt, input int gb);
        P1_X_L = 10'(xl); P1_X_R = 10'(xr); P1_Gap_T = 10'(gt); P1_Gap_B = 10'(gb);
    endtask

    // Bird mid-screen, both pipes far to the right.
    task automatic safe_geom();
        set_bird(300, 320, 220, 240);
        set_p0(600, 640, 100, 300);
        set_p1(600, 640, 100, 300);
    endtask

    // One P0 pass: wrap to the right to re-arm, then move behind the bird.
    task automatic pass_p0();
        set_p0(600, 640, 100, 300);
        tick(2);
        set_p0(250, 290, 100, 300);
        tick(2);
    endtask

    task automatic start_game();
        safe_geom();
        q_Flight = 1'b1;
        tick(1);
        q_Flight = 1'b0;
    endtask

    // Pipe-0 collision (gap 100-200 against bird Y 220-240).
    task automatic pipe_hit();
        set_p0(310, 350, 100, 200);
        tick(2);
    endtask

    task automatic ack_hit();
        Ack = 1'b1;
        tick(1);
        Ack = 1'b0;
        safe_geom();
        tick(1);
    endtask

    initial begin
        reset = 1'b1; q_Flight = 1'b0; Ack = 1'b0;
        safe_geom();
        tick(2);
        expect_out("reset", S_IDLE, 1'b0, 8'h00, 8'h00, 2'b00);
        compare_out();
        reset = 1'b0;
        tick(1);

        // Game start.
        start_game();
        expect_out("start", S_PLAY, 1'b0, 8'h00, 8'h00, 2'b00);
        compare_out();

        // Ack in QPlay is ignored.
        Ack = 1'b1; tick(1); Ack = 1'b0;
        expect_out("ack_in_play", S_PLAY, 1'b0, 8'h00, 8'h00, 2'b00);
        compare_out();

        // Pass counting: registered one edge, score on the next.
        set_p0(250, 290, 100, 300);
        tick(1);
        expect_out("pass_lat1", S_PLAY, 1'b0, 8'h00, 8'h00, 2'b00);
        compare_out();
        tick(1);
        expect_out("pass_first", S_PLAY, 1'b0, 8'h01, 8'h00, 2'b00);
        compare_out();
        tick(5);
        expect_out("pass_once", S_PLAY, 1'b0, 8'h01, 8'h00, 2'b00);
        compare_out();
        pass_p0();
        expect_out("pass_rearm", S_PLAY, 1'b0, 8'h02, 8'h00, 2'b00);
        compare_out();

        // Up to 09, then both pipes pass together -> 11 (BCD carry).
        for (int i = 0; i < 7; i++) pass_p0();
        expect_out("score_09", S_PLAY, 1'b0, 8'h09, 8'h00, 2'b00);
        compare_out();
        set_p0(600, 640, 100, 300);
        tick(2);
        set_p0(250, 290, 100, 300);
        set_p1(200, 280, 100, 300);
        tick(2);
        expect_out("dual_pass", S_PLAY, 1'b0, 8'h11, 8'h00, 2'b00);
        compare_out();

        // Pipe collision: Stop two edges after the geometry.
        set_p1(600, 640, 100, 300);
        set_p0(310, 350, 100, 200);
        tick(1);
        expect_out("hit_lat1", S_PLAY, 1'b0, 8'h11, 8'h00, 2'b00);
        compare_out();
        tick(1);
        expect_out("pipe_hit", S_HIT, 1'b1, 8'h11, 8'h11, 2'b01);
        compare_out();
        q_Flight = 1'b1;
        tick(10);
        q_Flight = 1'b0;
        expect_out("stop_held", S_HIT, 1'b1, 8'h11, 8'h11, 2'b01);
        compare_out();
        Ack = 1'b1;
        tick(1);
        Ack = 1'b0;
        expect_out("ack_release", S_IDLE, 1'b0, 8'h11, 8'h11, 2'b01);
        compare_out();

        // Floor beats pipe.
        start_game();
        expect_out("restart_clear", S_PLAY, 1'b0, 8'h00, 8'h11, 2'b00);
        compare_out();
        set_bird(300, 320, 460, 480);
        set_p0(310, 350, 100, 200);
        tick(2);
        expect_out("floor_prio", S_HIT, 1'b1, 8'h00, 8'h11, 2'b10);
        compare_out();
        ack_hit();

        // Ceiling beats pipe.
        start_game();
        set_bird(300, 320, 0, 20);
        set_p0(310, 350, 100, 200);
        tick(2);
        expect_out("ceil_prio", S_HIT, 1'b1, 8'h00, 8'h11, 2'b11);
        compare_out();
        ack_hit();

        // Saturation at 99 and high-score update.
        start_game();
        for (int i = 0; i < 98; i++) pass_p0();
        expect_out("score_98", S_PLAY, 1'b0, 8'h98, 8'h11, 2'b00);
        compare_out();
        for (int i = 0; i < 3; i++) pass_p0();
        expect_out("saturate", S_PLAY, 1'b0, 8'h99, 8'h11, 2'b00);
        compare_out();
        pipe_hit();
        expect_out("hs_99", S_HIT, 1'b1, 8'h99, 8'h99, 2'b01);
        compare_out();
        ack_hit();

        start_game();
        for (int i = 0; i < 5; i++) pass_p0();
        pipe_hit();
        expect_out("hs_kept", S_HIT, 1'b1, 8'h05, 8'h99, 2'b01);
        compare_out();
        ack_hit();

        // Hit and pass in the same cycle: score unchanged.
        start_game();
        set_p0(250, 290, 100, 300);
        set_p1(310, 350, 100, 200);
        tick(2);
        expect_out("hit_vs_pass", S_HIT, 1'b1, 8'h00, 8'h99, 2'b01);
        compare_out();
        ack_hit();

        // Asynchronous reset mid-game clears everything, HighScore included.
        start_game();
        pass_p0();
        expect_out("pre_reset", S_PLAY, 1'b0, 8'h01, 8'h99, 2'b00);
        compare_out();
        #2 reset = 1'b1;
        #1;
        expect_out("async_reset", S_IDLE, 1'b0, 8'h00, 8'h00, 2'b00);
        compare_out();
        tick(1);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
